// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of the memory/IO block.
// Port 0 is the CPU, port 1 a secondary master (boot loader / DMA).
// Reads hold mem_addr for READ_LATENCY cycles before sampling mem_rdata.
// Writes hold mem_we for exactly WRITE_HOLD cycles, so the memory's write
// cooldown commits each write once.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, two
// simultaneous requests are granted round robin. When it is undefined,
// port 0 has fixed priority.
module mem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int WRITE_HOLD   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_ack,
    output logic [7:0]  p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_ack,
    output logic [7:0]  p1_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        grant
);

    localparam logic [3:0] READ_CNT  = 4'(READ_LATENCY);
    localparam logic [3:0] WRITE_CNT = 4'(WRITE_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic [7:0]  p0_rdata_q, p0_rdata_d;
    logic [7:0]  p1_rdata_q, p1_rdata_d;

    logic        win_s;
    logic        sel_we_s;
    logic [15:0] sel_addr_s;
    logic [7:0]  sel_wdata_s;

    // Arbitration: choose which port wins when the arbiter is idle.
    always_comb begin
        win_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (p0_req && p1_req) begin
            win_s = ~last_grant_q;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        if (p0_req) begin
            win_s = 1'b0;
        end else if (p1_req) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
    end

    // Request field mux: select the winner's request fields.
    always_comb begin
        sel_we_s    = win_s ? p1_we    : p0_we;
        sel_addr_s  = win_s ? p1_addr  : p0_addr;
        sel_wdata_s = win_s ? p1_wdata : p0_wdata;
    end

    // Next-state logic: sequence one read or write transaction at a time.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d      = win_s;
                    last_grant_d = win_s;
                    mem_addr_d   = sel_addr_s;
                    mem_wdata_d  = sel_wdata_s;
                    if (sel_we_s) begin
                        state_d  = ST_WRITE;
                        cnt_d    = WRITE_CNT;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        cnt_d    = READ_CNT;
                        mem_we_d = 1'b0;
                    end
                end else begin
                    mem_we_d = 1'b0;
                end
            end
            ST_READ: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (grant_q) begin
                        p1_rdata_d = mem_rdata;
                        p1_ack_d   = 1'b1;
                    end else begin
                        p0_rdata_d = mem_rdata;
                        p0_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WRITE: begin
                if (cnt_q == 4'd1) begin
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    mem_we_d = 1'b0;
                    if (grant_q) begin
                        p1_ack_d = 1'b1;
                    end else begin
                        p0_ack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 4'd0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 8'd0;
            mem_we_q     <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= 8'd0;
            p1_rdata_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign grant     = grant_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It uses a transaction-level reference
// model, per-port expected-response queues and a negedge monitor.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int RL = 2;
    localparam int WH = 4;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          drop;
        int          gap;
    } cmd_t;

    typedef struct {
        int          ack_cyc;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p0_addr = 16'd0, p1_addr = 16'd0;
    logic [7:0]  p0_wdata = 8'd0, p1_wdata = 8'd0;
    logic        p0_ack, p1_ack, mem_we, busy, grant;
    logic [7:0]  p0_rdata, p1_rdata, mem_wdata, mem_rdata;
    logic [15:0] mem_addr;

    mem_arbiter #(.READ_LATENCY(RL), .WRITE_HOLD(WH)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // ---------------- memory model (cooldown: one commit per WH cycles) ----
    logic [7:0] tb_mem [0:65535];
    int commits = 0;
    int cool = 0;
    assign mem_rdata = tb_mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we && cool == 0) begin
            tb_mem[mem_addr] <= mem_wdata;
            commits <= commits + 1;
            cool <= WH - 1;
        end else if (cool > 0) begin
            cool <= cool - 1;
        end
    end

    // ---------------- reference model state --------------------------------
    logic [7:0] model_mem [0:65535];
    int          cyc = 0;
    int          free_cyc = 0;
    logic        last_g = 1'b1;
    bit          have_txn = 1'b0;
    int          cur_start = 0, cur_lat = 0;
    logic        cur_we = 1'b0, cur_port = 1'b0;
    logic [15:0] cur_addr = 16'd0;
    logic [7:0]  cur_wdata = 8'd0;
    exp_t        exp0[$], exp1[$];
    cmd_t        cmdq0[$], cmdq1[$];
    bit          drv_busy0 = 1'b0, drv_busy1 = 1'b0;
    logic [7:0]  exp_rd [2];
    int          exp_commits = 0;
    int          ack_order[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]    <= 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
            model_mem[i]  = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        end
        tb_mem[16'h8010]    <= 8'h5A;
        model_mem[16'h8010]  = 8'h5A;
        exp_rd[0] = 8'd0;
        exp_rd[1] = 8'd0;
    end

    // Reference model: at each rising edge, decide whether a grant happens
    // and what the granted port must later observe.
    initial forever begin
        int   c;
        logic w;
        exp_t e;
        @(posedge clk);
        c = cyc;
        cyc = cyc + 1;
        if (!reset) begin
            exp0.delete();
            exp1.delete();
            last_g = 1'b1;
            have_txn = 1'b0;
            cur_port = 1'b0; cur_we = 1'b0; cur_addr = 16'd0; cur_wdata = 8'd0;
            free_cyc = c;
        end else if (c >= free_cyc && (p0_req || p1_req)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = (p0_req && p1_req) ? ~last_g : p1_req;
`else
            w = p0_req ? 1'b0 : 1'b1;
`endif
            last_g = w;
            cur_port  = w;
            cur_we    = w ? p1_we : p0_we;
            cur_addr  = w ? p1_addr : p0_addr;
            cur_wdata = w ? p1_wdata : p0_wdata;
            cur_lat   = cur_we ? WH : RL;
            cur_start = c;
            have_txn  = 1'b1;
            free_cyc  = c + 1 + cur_lat;
            e.ack_cyc = c + 1 + cur_lat;
            e.we = cur_we; e.addr = cur_addr; e.wdata = cur_wdata;
            e.rdata = model_mem[cur_addr];
            if (cur_we) model_mem[cur_addr] = cur_wdata;
            if (w) exp1.push_back(e); else exp0.push_back(e);
        end
    end

    // Check one port's ack/rdata against the scoreboard.
    task automatic mon_port(input int p, input int k);
        logic got;
        logic [7:0] rd;
        exp_t e;
        bit   due;
        got = (p == 0) ? p0_ack : p1_ack;
        rd  = (p == 0) ? p0_rdata : p1_rdata;
        due = (p == 0) ? (exp0.size() > 0 && exp0[0].ack_cyc <= k)
                       : (exp1.size() > 0 && exp1[0].ack_cyc <= k);
        if (due) begin
            e = (p == 0) ? exp0.pop_front() : exp1.pop_front();
            check($sformatf("p%0d_ack_due", p), 32'(got), 32'd1);
            if (got) ack_order.push_back(p);
            if (e.we) begin
                exp_commits++;
                check("write_commits", 32'(commits), 32'(exp_commits));
                check("mem_content", 32'(tb_mem[e.addr]), 32'(e.wdata));
            end else begin
                exp_rd[p] = e.rdata;
            end
        end else begin
            check($sformatf("p%0d_ack_idle", p), 32'(got), 32'd0);
        end
        check($sformatf("p%0d_rdata", p), 32'(rd), 32'(exp_rd[p]));
    endtask

    // Monitor: sample all DUT outputs on the falling edge.
    initial forever begin
        int   k;
        logic eb;
        @(negedge clk);
        if (!reset) begin
            exp_rd[0] = 8'd0;
            exp_rd[1] = 8'd0;
            exp_commits = commits;
        end else begin
            k  = cyc;
            eb = have_txn && (k > cur_start) && (k <= cur_start + cur_lat);
            check("busy", 32'(busy), 32'(eb));
            check("mem_we", 32'(mem_we), 32'(eb && cur_we));
            check("mem_addr", 32'(mem_addr), 32'(cur_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
            check("grant", 32'(grant), 32'(cur_port));
            mon_port(0, k);
            mon_port(1, k);
        end
    end

    // ---------------- port drivers -----------------------------------------
    task automatic set_fields(input int p, input logic r, input cmd_t c);
        if (p == 0) begin
            p0_req = r; p0_we = c.we; p0_addr = c.addr; p0_wdata = c.wdata;
        end else begin
            p1_req = r; p1_we = c.we; p1_addr = c.addr; p1_wdata = c.wdata;
        end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) p0_req = r; else p1_req = r;
    endtask

    task automatic run_driver(input int p);
        cmd_t c;
        int   t;
        bit   done;
        int   qs;
        forever begin
            qs = (p == 0) ? cmdq0.size() : cmdq1.size();
            if (reset && qs > 0) begin
                c = (p == 0) ? cmdq0.pop_front() : cmdq1.pop_front();
                if (p == 0) drv_busy0 = 1'b1; else drv_busy1 = 1'b1;
                repeat (c.gap) @(negedge clk);
                set_fields(p, 1'b1, c);
                t = 0;
                done = 1'b0;
                while (!done) begin
                    @(negedge clk);
                    t++;
                    if (!reset) done = 1'b1;
                    else if ((p == 0) ? p0_ack : p1_ack) done = 1'b1;
                    else if (t > 200) begin
                        vectors++; errors++;
                        $display("FAIL driver_timeout: port %0d got no ack in 200 cycles, required an ack", p);
                        done = 1'b1;
                    end
                    else if (c.drop && t == 1) set_req(p, 1'b0);
                    else done = 1'b0;
                end
                qs = (p == 0) ? cmdq0.size() : cmdq1.size();
                if (!reset || qs == 0) set_req(p, 1'b0);
                else if (((p == 0) ? cmdq0[0].gap : cmdq1[0].gap) != 0) set_req(p, 1'b0);
                else set_req(p, 1'b1);
                if (p == 0) drv_busy0 = 1'b0; else drv_busy1 = 1'b0;
            end else begin
                set_req(p, 1'b0);
                @(negedge clk);
            end
        end
    endtask

    initial run_driver(0);
    initial run_driver(1);

    task automatic push_cmd(input int p, input logic we, input logic [15:0] a,
                            input logic [7:0] d, input bit drop, input int gap);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.drop = drop; c.gap = gap;
        if (p == 0) cmdq0.push_back(c); else cmdq1.push_back(c);
    endtask

    task automatic wait_idle(input int max_cycles);
        int t = 0;
        while ((cmdq0.size() > 0 || cmdq1.size() > 0 || drv_busy0 || drv_busy1) && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle_timeout", 32'(t < max_cycles), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- directed and random sequence -------------------------
    initial begin
        int c0;
        int t;
        int ord [7];
        repeat (3) @(negedge clk);
        check("reset_outputs", {p0_ack, p1_ack, mem_we, busy, grant, p0_rdata, p1_rdata},
              32'd0);
        check("reset_mem_addr", 32'({mem_addr, mem_wdata}), 32'd0);
        #2 reset = 1'b1;

        // Test 1: idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_outputs", {p0_ack, p1_ack, mem_we, busy, grant, mem_addr}, 32'd0);
        end

        // Test 2: port 0 read of 0x8010.
        push_cmd(0, 1'b0, 16'h8010, 8'h00, 1'b0, 0);
        wait_idle(50);
        check("t2_p0_rdata", 32'(p0_rdata), 32'h5A);
        check("t2_p1_rdata", 32'(p1_rdata), 32'h00);

        // Test 3: port 1 write 0xA5 to 0xFFF8, committed exactly once.
        c0 = commits;
        push_cmd(1, 1'b1, 16'hFFF8, 8'hA5, 1'b0, 0);
        wait_idle(50);
        check("t3_mem_fff8", 32'(tb_mem[16'hFFF8]), 32'hA5);
        check("t3_commit_once", 32'(commits - c0), 32'd1);
        check("t3_grant", 32'(grant), 32'd1);

        // Test 4: contention with back-to-back requests on both ports.
        ack_order.delete();
        for (int i = 0; i < 5; i++)
            push_cmd(0, 1'b0, 16'($urandom_range(0, 65535)), 8'($urandom), 1'b0, 0);
        push_cmd(1, 1'b1, 16'h4000, 8'h11, 1'b0, 0);
        push_cmd(1, 1'b1, 16'h4001, 8'h22, 1'b0, 0);
        wait_idle(200);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ord = '{0, 1, 0, 1, 0, 0, 0};
`else
        ord = '{0, 0, 0, 0, 0, 1, 1};
`endif
        check("t4_ack_count", 32'(ack_order.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            check($sformatf("t4_order%0d", i),
                  32'((i < ack_order.size()) ? ack_order[i] : -1), 32'(ord[i]));

        // Test 6: request dropped one cycle after grant.
        ack_order.delete();
        push_cmd(0, 1'b0, 16'h8010, 8'h00, 1'b1, 0);
        wait_idle(50);
        repeat (5) @(negedge clk);
        check("t6_one_ack", 32'(ack_order.size()), 32'd1);
        check("t6_not_busy", 32'(busy), 32'd0);

        // Test 5: reset during the second mem_we cycle of a write.
        push_cmd(0, 1'b1, 16'h1234, 8'h77, 1'b0, 0);
        t = 0;
        while (!mem_we && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("t5_we_seen", 32'(mem_we), 32'd1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 check("t5_we_drop", 32'(mem_we), 32'd0);
        check("t5_no_ack", {p0_ack, p1_ack, busy}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_ack_rst", {p0_ack, p1_ack, mem_we}, 32'd0);
        end
        #2 reset = 1'b1;
        wait_idle(20);
        ack_order.delete();
        push_cmd(0, 1'b0, 16'h8010, 8'h00, 1'b0, 0);
        wait_idle(50);
        check("t5_after_reset_acks", 32'(ack_order.size()), 32'd1);
        check("t5_after_reset_rdata", 32'(p0_rdata), 32'h5A);

        // Random traffic on both ports.
        for (int i = 0; i < 60; i++) begin
            push_cmd(0, 1'($urandom), 16'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3));
            push_cmd(1, 1'($urandom), 16'($urandom), 8'($urandom), 1'b0, $urandom_range(0, 3));
        end
        wait_idle(8000);
        check("scoreboard_drained", 32'(exp0.size() + exp1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
